// File: rtl/ppi_strobed_io_if.sv
// rtl/ppi_strobed_io_if.sv - CPU-side register bus of the strobed PPI
interface ppi_strobed_io_if #(
  parameter int PW = 8
);
  logic          cs_n;
  logic          rd_n;
  logic          wr_n;
  logic [1:0]    a;
  logic [PW-1:0] data_in;
  logic [PW-1:0] data_out;
  logic          data_oe;

  modport master (
    output cs_n, rd_n, wr_n, a, data_in,
    input  data_out, data_oe
  );

  modport slave (
    input  cs_n, rd_n, wr_n, a, data_in,
    output data_out, data_oe
  );
endinterface

// File: rtl/ppi_strobed_io.sv
// rtl/ppi_strobed_io.sv - PPI ports A/B/C with mode 1 strobed handshakes, BSR, interrupts; PPI_SYNC_EN adds pin synchronisers
module ppi_strobed_io #(
  parameter int PW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  ppi_strobed_io_if.slave bus,
  input  logic [PW-1:0]   pa_i,
  output logic [PW-1:0]   pa_o,
  output logic            pa_oe_o,
  input  logic [PW-1:0]   pb_i,
  output logic [PW-1:0]   pb_o,
  output logic            pb_oe_o,
  input  logic [PW-1:0]   pc_i,
  output logic [PW-1:0]   pc_o,
  output logic [PW-1:0]   pc_oe_o,
  output logic            intr_a_o,
  output logic            intr_b_o
);
  localparam int BW = $clog2(PW);
  localparam logic [BW-1:0] IDX_PC2 = BW'(2);
  localparam logic [BW-1:0] IDX_PC4 = BW'(4);
  localparam logic [BW-1:0] IDX_PC6 = BW'(6);

  typedef enum logic {S_EMPTY, S_FULL} hs_state_e;

  if (!(PW == 8 || PW == 16) || SYNC_STAGES < 1) begin : g_bad_param
    $error("ppi_strobed_io: PW must be 8 or 16 and SYNC_STAGES at least 1");
  end

  logic          wr_q, wr_prev_q, rd_q, rd_prev_q, data_oe_q;
  logic [1:0]    a_q, rd_a_q;
  logic [PW-1:0] din_q, dout_q;
  logic [7:0]    ctrl_q;
  logic [PW-1:0] pa_out_q, pb_out_q, pc_out_q, pa_lat_q, pb_lat_q;
  logic [2:0]    hs_d_q;
  hs_state_e     st_a_q, st_b_q;
  logic          intr_a_q, intr_b_q, inte_a_q, inte_b_q;
  logic [PW-1:0] pa_s, pb_s, pc_s;

`ifdef PPI_SYNC_EN
  logic [3*PW-1:0] sync_q [SYNC_STAGES];

  // Pin synchroniser: all three ports move together so latched data stays aligned with its strobe
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {pc_i, pb_i, pa_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign {pc_s, pb_s, pa_s} = sync_q[SYNC_STAGES-1];
`else
  assign pa_s = pa_i;
  assign pb_s = pb_i;
  assign pc_s = pc_i;
`endif

  // Control word decode
  logic mode1_a, a_in, pcu_in, mode1_b, b_in, pcl_in;
  assign mode1_a = (ctrl_q[6:5] == 2'b01);
  assign a_in    = ctrl_q[4];
  assign pcu_in  = ctrl_q[3];
  assign mode1_b = ctrl_q[2];
  assign b_in    = ctrl_q[1];
  assign pcl_in  = ctrl_q[0];

  // Bus events: a write commits on the first qualified cycle, read side effects on the trailing one
  logic wr_commit, rd_lead, rd_trail, ctrl_wr, mode_set, bsr, port_wr_a, port_wr_b;
  logic rd_trail_a, rd_trail_b;
  logic [BW-1:0] bsr_idx;
  assign wr_commit  = wr_q & ~wr_prev_q;
  assign rd_lead    = rd_q & ~rd_prev_q;
  assign rd_trail   = ~rd_q & rd_prev_q;
  assign ctrl_wr    = wr_commit && (a_q == 2'b11);
  assign mode_set   = ctrl_wr & din_q[7];
  assign bsr        = ctrl_wr & ~din_q[7];
  assign bsr_idx    = din_q[BW:1];
  assign port_wr_a  = wr_commit && (a_q == 2'b00);
  assign port_wr_b  = wr_commit && (a_q == 2'b01);
  assign rd_trail_a = rd_trail && (rd_a_q == 2'b00);
  assign rd_trail_b = rd_trail && (rd_a_q == 2'b01);

  // Handshake pin edges; group A uses STB on PC4 when input, ACK on PC6 when output
  logic hs_a_s, hs_a_d, hs_a_fall, hs_a_rise, hs_b_fall, hs_b_rise;
  assign hs_a_s    = a_in ? pc_s[4] : pc_s[6];
  assign hs_a_d    = a_in ? hs_d_q[1] : hs_d_q[2];
  assign hs_a_fall = ~hs_a_s & hs_a_d;
  assign hs_a_rise = hs_a_s & ~hs_a_d;
  assign hs_b_fall = ~pc_s[2] & hs_d_q[0];
  assign hs_b_rise = pc_s[2] & ~hs_d_q[0];

  // Status bits derived from the handshake state of each group
  logic ibf_a, obf_a_n, ibf_b, obf_b_n;
  assign ibf_a   = a_in & (st_a_q == S_FULL);
  assign obf_a_n = ~(~a_in & (st_a_q == S_FULL));
  assign ibf_b   = b_in & (st_b_q == S_FULL);
  assign obf_b_n = ~(~b_in & (st_b_q == S_FULL));

  // Port C output/readback/enable with mode 1 status bits overlaid on their pin positions
  logic [PW-1:0] pc_view, pc_rd, pc_oe;
  always_comb begin
    pc_view = pc_out_q;
    pc_rd   = pc_s;
    pc_oe   = {{(PW-4){~pcu_in}}, {4{~pcl_in}}};
    if (mode1_a) begin
      pc_view[3] = intr_a_q;
      pc_view[5] = ibf_a;
      pc_view[7] = obf_a_n;
      pc_rd[3]   = intr_a_q;
      pc_rd[5]   = ibf_a;
      pc_rd[7]   = obf_a_n;
      pc_oe[7:3] = 5'b10101;
    end
    if (mode1_b) begin
      pc_view[0] = intr_b_q;
      pc_view[1] = b_in ? ibf_b : obf_b_n;
      pc_rd[0]   = intr_b_q;
      pc_rd[1]   = b_in ? ibf_b : obf_b_n;
      pc_oe[2:0] = 3'b011;
    end
  end

  // Read data selection; mode 1 input ports return the strobed latch instead of the pins
  logic [PW-1:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (a_q)
      2'b00:   rd_mux = (mode1_a & a_in) ? pa_lat_q : pa_s;
      2'b01:   rd_mux = (mode1_b & b_in) ? pb_lat_q : pb_s;
      2'b10:   rd_mux = pc_rd;
      default: rd_mux[7:0] = ctrl_q;
    endcase
  end

  // Bus capture, register writes, and both groups' EMPTY/FULL handshake machines
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q <= 1'b0; wr_prev_q <= 1'b0; rd_q <= 1'b0; rd_prev_q <= 1'b0; data_oe_q <= 1'b0;
      a_q <= '0; rd_a_q <= '0; din_q <= '0; dout_q <= '0;
      ctrl_q <= 8'h9B;
      pa_out_q <= '0; pb_out_q <= '0; pc_out_q <= '0; pa_lat_q <= '0; pb_lat_q <= '0;
      hs_d_q <= '0;
      st_a_q <= S_EMPTY; st_b_q <= S_EMPTY;
      intr_a_q <= 1'b0; intr_b_q <= 1'b0; inte_a_q <= 1'b0; inte_b_q <= 1'b0;
    end else begin
      wr_q      <= ~bus.cs_n & ~bus.wr_n & bus.rd_n;
      rd_q      <= ~bus.cs_n & ~bus.rd_n & bus.wr_n;
      wr_prev_q <= wr_q;
      rd_prev_q <= rd_q;
      a_q       <= bus.a;
      din_q     <= bus.data_in;
      data_oe_q <= rd_q;
      hs_d_q    <= {pc_s[6], pc_s[4], pc_s[2]};
      if (rd_lead) begin
        dout_q <= rd_mux;
        rd_a_q <= a_q;
      end
      if (mode_set) begin
        ctrl_q   <= din_q[7:0];
        pa_out_q <= '0; pb_out_q <= '0; pc_out_q <= '0;
        st_a_q   <= S_EMPTY; st_b_q <= S_EMPTY;
        intr_a_q <= 1'b0; intr_b_q <= 1'b0; inte_a_q <= 1'b0; inte_b_q <= 1'b0;
      end else begin
        if (bsr) begin
          if (mode1_a && bsr_idx == (a_in ? IDX_PC4 : IDX_PC6)) inte_a_q <= din_q[0];
          else if (mode1_b && bsr_idx == IDX_PC2)               inte_b_q <= din_q[0];
          else                                                   pc_out_q[bsr_idx] <= din_q[0];
        end
        if (port_wr_a) pa_out_q <= din_q;
        if (port_wr_b) pb_out_q <= din_q;
        if (mode1_a) begin
          if (a_in) begin
            if (hs_a_rise && st_a_q == S_FULL && inte_a_q) intr_a_q <= 1'b1;
            if (rd_trail_a) begin st_a_q <= S_EMPTY; intr_a_q <= 1'b0; end
            if (hs_a_fall)  begin st_a_q <= S_FULL;  pa_lat_q <= pa_s; end
          end else begin
            if (hs_a_rise && st_a_q == S_EMPTY && inte_a_q) intr_a_q <= 1'b1;
            if (hs_a_fall) st_a_q <= S_EMPTY;
            if (port_wr_a) begin st_a_q <= S_FULL; intr_a_q <= 1'b0; end
          end
        end
        if (mode1_b) begin
          if (b_in) begin
            if (hs_b_rise && st_b_q == S_FULL && inte_b_q) intr_b_q <= 1'b1;
            if (rd_trail_b) begin st_b_q <= S_EMPTY; intr_b_q <= 1'b0; end
            if (hs_b_fall)  begin st_b_q <= S_FULL;  pb_lat_q <= pb_s; end
          end else begin
            if (hs_b_rise && st_b_q == S_EMPTY && inte_b_q) intr_b_q <= 1'b1;
            if (hs_b_fall) st_b_q <= S_EMPTY;
            if (port_wr_b) begin st_b_q <= S_FULL; intr_b_q <= 1'b0; end
          end
        end
      end
    end
  end

  assign bus.data_out = dout_q;
  assign bus.data_oe  = data_oe_q;
  assign pa_o         = pa_out_q;
  assign pa_oe_o      = ~a_in;
  assign pb_o         = pb_out_q;
  assign pb_oe_o      = ~b_in;
  assign pc_o         = pc_view;
  assign pc_oe_o      = pc_oe;
  assign intr_a_o     = intr_a_q;
  assign intr_b_o     = intr_b_q;
endmodule
